// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit time-multiplexed 7-segment scanner.
//   Accepts a 16-bit hex value plus four decimal points through a valid/ready
//   handshake into a pending buffer; the pending buffer is copied into the
//   active (displayed) buffer only at a frame boundary, so a frame never tears.
//   Each digit slot starts with BLANK_CYCLES cycles of all digits off.
//   Optional leading-zero blanking suppresses segments of leading zero digits.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_value[15:0]    nibble k drives digit k (digit 0 rightmost)
//   in_dp[3:0]        decimal point per digit, active-high
//   in_valid/in_ready handshake; in_ready = pending buffer empty
//   lzb_en            leading-zero blanking enable
//   seg[6:0]          segments a..g, active-high, registered
//   dp                decimal point of the driven digit, registered
//   digit_en[3:0]     one-hot digit select (zero while blanking), registered
//   frame_tick        one-cycle pulse on the last cycle of slot 3
module seg7_scan_mux #(
  parameter int unsigned PRESCALE     = 10000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_value,
  input  logic [3:0]  in_dp,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        lzb_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  digit_en,
  output logic        frame_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK,
    DRIVE
  } phase_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  phase_e        phase_q, phase_d;

  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_full_q, pend_full_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_dp_q, act_dp_d;

  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit_en_q, digit_en_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_end;
  logic          frame_end;
  logic [15:0]   act_shift;
  logic          lz_blank;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot counter, digit index and phase FSM
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    phase_d   = phase_q;
    if (slot_end) begin
      phase_d = BLANK;
    end else if (cnt_q == BLANK_LAST) begin
      phase_d = DRIVE;
    end
  end

  // Double buffer. Accept and transfer never coincide: accept needs pending
  // empty, transfer needs pending full, so a collision just lands in pending.
  always_comb begin
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    if (in_valid && !pend_full_q) begin
      pend_val_d  = in_value;
      pend_dp_d   = in_dp;
      pend_full_d = 1'b1;
    end else if (frame_end && pend_full_q) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
  end

  // Outputs are computed from next-state so the registered outputs line up
  // with the phase the counter has just decided on.
  always_comb begin
    act_shift    = act_val_q >> {idx_d, 2'b00};
    // After the shift, upper nibbles are zero-filled, so all-zero means
    // nibbles idx..3 are zero.
    lz_blank     = lzb_en && (idx_d != 2'd0) && (act_shift == '0);
    seg_d        = '0;
    dp_d         = 1'b0;
    digit_en_d   = '0;
    if (phase_d == DRIVE) begin
      digit_en_d = 4'b0001 << idx_d;
      dp_d       = act_dp_q[idx_d];
      seg_d      = lz_blank ? '0 : hex2seg(act_shift[3:0]);
    end
    frame_tick_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      phase_q      <= BLANK;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign in_ready   = !pend_full_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for seg7_scan_mux (PRESCALE=8, BLANK_CYCLES=2).
//   A predictor derives each cycle's expected outputs from the cycle number
//   since reset and a simple pending/active buffer model, and queues them;
//   a monitor pops and compares one entry per clock.
module tb_seg7_scan_mux;

  localparam int unsigned PS    = 8;
  localparam int unsigned BL    = 2;
  localparam int unsigned FRAME = 4 * PS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic        in_valid = 1'b0;
  logic        lzb_en = 1'b0;
  logic        in_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .PRESCALE    (PS),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_value  (in_value),
    .in_dp     (in_dp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lzb_en    (lzb_en),
    .seg       (seg),
    .dp        (dp),
    .digit_en  (digit_en),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] den;
    logic       ft;
    logic       rdy;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  int unsigned c;
  int unsigned n, s, p;
  logic        m_full;
  logic [15:0] m_pend, m_act, upper;
  logic [3:0]  m_pdp, m_adp;
  logic        acc;
  obs_t        e_p;

  // Predictor: c = index of the cycle ending at this edge; builds the
  // outputs expected during cycle c+1.
  initial begin
    c = 0; m_full = 1'b0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        c = 0; m_full = 1'b0; m_act = '0; m_adp = '0;
        exp_q.delete();
      end else begin
        n = c + 1;
        s = (n / PS) % 4;
        p = n % PS;
        e_p = '0;
        if (p >= BL) begin
          e_p.den = 4'(1 << s);
          e_p.dp  = m_adp[s];
          upper   = m_act >> (4 * s);
          e_p.seg = (lzb_en && s != 0 && upper == 16'h0) ? 7'h00 : SEG_TBL[upper[3:0]];
        end
        e_p.ft = ((n % FRAME) == FRAME - 1);
        acc = in_valid && !m_full;
        if ((c % FRAME) == FRAME - 1 && m_full) begin
          m_act  = m_pend;
          m_adp  = m_pdp;
          m_full = 1'b0;
        end
        if (acc) begin
          m_pend = in_value;
          m_pdp  = in_dp;
          m_full = 1'b1;
        end
        e_p.rdy = !m_full;
        exp_q.push_back(e_p);
        c++;
      end
    end
  end

  // Monitor
  obs_t e_m, a_m;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        a_m = '{seg: seg, dp: dp, den: digit_en, ft: frame_tick, rdy: in_ready};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
        end else begin
          e_m = exp_q.pop_front();
          if (a_m !== e_m) begin
            errors++;
            $display("FAIL scan t=%0t got seg=%h dp=%b en=%b ft=%b rdy=%b want seg=%h dp=%b en=%b ft=%b rdy=%b",
                     $time, a_m.seg, a_m.dp, a_m.den, a_m.ft, a_m.rdy,
                     e_m.seg, e_m.dp, e_m.den, e_m.ft, e_m.rdy);
          end
        end
      end
    end
  end

  task automatic check_reset(input string name);
    checks++;
    if (seg !== 7'h00 || dp !== 1'b0 || digit_en !== 4'h0 || frame_tick !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s got seg=%h dp=%b en=%b ft=%b rdy=%b want seg=00 dp=0 en=0000 ft=0 rdy=1",
               name, seg, dp, digit_en, frame_tick, in_ready);
    end
  endtask

  task automatic idle(input int unsigned k);
    repeat (k) @(negedge clk);
  endtask

  // Offer a value and hold it until accepted.
  task automatic offer(input logic [15:0] v, input logic [3:0] d);
    int unsigned i;
    @(negedge clk);
    in_value = v;
    in_dp    = d;
    in_valid = 1'b1;
    i = 0;
    while (!in_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout value=%h got in_ready=0 want 1 within 200 cycles", v);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ft();
    int unsigned i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_tick && i < 100);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout got frame_tick=0 want 1 within 100 cycles");
    end
  endtask

  task automatic wait_drive();
    int unsigned i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (digit_en == 4'h0 && i < 20);
    if (digit_en == 4'h0) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout got digit_en=0000 want nonzero within 20 cycles");
    end
  endtask

  logic [15:0] rv;

  initial begin
    #3 check_reset("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);

    // Load and scan
    offer(16'h1234, 4'b0001);
    wait_ft();
    idle(40);

    // Back-pressure: second offer is held until the boundary
    offer(16'hAAAA, 4'b0000);
    offer(16'h5555, 4'b1010);
    idle(70);

    // Boundary collision: offer on the frame_tick cycle
    wait_ft();
    in_value = 16'hBEEF;
    in_dp    = 4'b0110;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    idle(80);

    // Leading-zero blanking
    lzb_en = 1'b1;
    offer(16'h0040, 4'b0000);
    idle(70);
    offer(16'h0000, 4'b0001);
    idle(70);
    lzb_en = 1'b0;
    idle(40);

    // Async reset mid-DRIVE with pending full
    wait_ft();
    offer(16'hC0DE, 4'hF);
    wait_drive();
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);

    // Randomized traffic with random leading zeros and lzb toggling
    repeat (30) begin
      lzb_en = 1'($urandom_range(0, 1));
      rv = 16'($urandom);
      rv = rv >> (4 * $urandom_range(0, 3));
      offer(rv, 4'($urandom));
      idle($urandom_range(0, 40));
    end
    idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Four-digit time-multiplexed 7-segment scanner that sits downstream of the hex counter/decoder path and drives a common-segment LED module from `uo_out`. It accepts a 16-bit value (four hex nibbles) plus decimal points through a valid/ready handshake. New values are double-buffered so they only take effect at a frame boundary, which prevents tearing. Digits are scanned round-robin with a blanking interval to suppress ghosting, and optional leading-zero blanking.

## Interface
- `PRESCALE`, default 10000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot with all digits off; ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_value`  in  16  nibble k = digit k; digit 0 is rightmost.
- `in_dp`  in  4  decimal point per digit; active-high.
- `in_valid`  in  1  `in_value`/`in_dp` offered.
- `in_ready`  out  1  pending buffer empty; transfer occurs when `in_valid && in_ready` at a rising edge.
- `lzb_en`  in  1  leading-zero blanking enable; sampled every cycle.
- `seg`  out  7  segments a..g on bits 0..6; active-high; registered.
- `dp`  out  1  decimal point of the driven digit; registered.
- `digit_en`  out  4  one-hot active-high digit select, or all zero during blanking; registered.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of slot 3.

## Operation
- Internal state:
  - slot counter `cnt` (0..`PRESCALE`-1);
  - digit index `idx` (0..3, wraps 3→0);
  - phase FSM {BLANK, DRIVE};
  - pending buffer (value, dp, full flag);
  - active buffer (value, dp).
- Phase FSM, per slot:
  - BLANK while `cnt` < `BLANK_CYCLES`; transitions to DRIVE when `cnt` = `BLANK_CYCLES`-1.
  - DRIVE otherwise.
  - At `cnt` = `PRESCALE`-1: `cnt`←0, `idx`←`idx`+1 mod 4, phase←BLANK.
- Outputs:
  - BLANK: `digit_en`=0, `seg`=0, `dp`=0.
  - DRIVE: `digit_en`=1<<`idx`; `seg`=decode(active nibble `idx`); `dp`=active dp[`idx`].
- Decode (hex→seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Leading-zero blanking, when `lzb_en`=1:
  - digit k (k=3,2,1) is blank if nibbles k..3 are all zero;
  - a blank digit drives `seg`=0, but `digit_en` and `dp` are driven normally;
  - digit 0 is never blanked.
- Handshake:
  - `in_ready` = !pending_full.
  - On accept: pending←inputs, full←1.
  - At the frame boundary edge (end of slot 3, same edge as `frame_tick` high): if full, active←pending and full←0.
- Simultaneous accept and frame boundary: the accepted data goes to pending only. Nothing transfers on that edge, because pending was empty. It transfers at the next frame boundary.
- `in_valid` while `in_ready`=0: ignored; the data must be held by the producer.
- Reset (async assert, any time, including mid-slot or with pending full):
  - `cnt`=0, `idx`=0, phase=BLANK, pending empty, active value=0, active dp=0;
  - outputs `seg`=0, `dp`=0, `digit_en`=0, `frame_tick`=0, `in_ready`=1.
  - Release is synchronous to `clk`; scanning restarts at slot 0 / BLANK.

## Timing
- Slot = `PRESCALE` cycles; frame = 4×`PRESCALE` cycles. Default at 10 MHz: 1 ms slot, 250 Hz frame.
- Registered outputs reflect the state one cycle after the counter decision: `digit_en` rises on cycle `BLANK_CYCLES` of the slot (counting from 0) and falls on cycle 0 of the next slot.
- `in_ready` falls the cycle after accept. It rises the cycle after the frame-boundary transfer.
- Worst-case accept-to-display latency:
  - accept→active: 4×`PRESCALE` cycles;
  - active→digit 0 visible: +`BLANK_CYCLES`+1 cycles.
- `lzb_en` and decode are combinational from active state into the output registers: 1-cycle latency.
- Counter width: `$clog2(PRESCALE)` bits; no overflow beyond `PRESCALE`-1.

## Test plan
All scenarios use `PRESCALE`=8, `BLANK_CYCLES`=2.
- **Reset:** assert `rst_n`=0 mid-DRIVE with pending full → `seg`=0, `digit_en`=0, `in_ready`=1 immediately (async). After release, the first `digit_en`=0001 appears on cycle 2 with `seg`=3F.
- **Load and scan:** load 0x1234, dp=0001 → after the next `frame_tick`, slots show `digit_en` 0001/0010/0100/1000 with `seg` 66/4F/5B/06. `dp`=1 only in slot 0. Each slot has 2 blank cycles followed by 6 driven cycles.
- **Handshake back-pressure:** accept 0xAAAA, then hold `in_valid` with 0x5555 → `in_ready`=0 until the frame boundary. The display shows AAAA for a full frame, then 0x5555 is accepted.
- **Boundary collision:** accept 0xBEEF on the `frame_tick` cycle → it is not displayed in the next frame. It is displayed after the following `frame_tick`.
- **Leading-zero blanking:** value 0x0040 with `lzb_en`=1 → digits 3 and 2 give `seg`=00, digit 1 gives 66, digit 0 gives 3F. Value 0x0000 → only digit 0 shows 3F. With `lzb_en`=0, all four digits show 3F.
- **Wrap:** run 3 frames → `frame_tick` fires every 32 cycles and `idx` wraps 3→0 without a skipped or extra slot.
